// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 bit mux between four requesters, with a
// bounded hold time per grant so a busy requester cannot starve the others.

module mux_st (
   input  logic [3:0] in,
   input  logic [1:0] sel,
   output logic       out
);
   assign out = in[sel];
endmodule

// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no owner; gnt=0, out_valid=0, sel keeps last owner
// GRANT | one owner in gnt/sel; hold_cnt counts cycles of this grant
module mux_rr_arbiter #(
   parameter int unsigned MAX_HOLD = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] in,
   output logic [3:0] gnt,
   output logic [1:0] sel,
   output logic       out_valid,
   output logic       out
);
   localparam int HW = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0]    state;
   logic [1:0]    ptr;
   logic [HW-1:0] hold_cnt;

   logic          any_req;
   logic          release_now;
   logic [1:0]    search_base;
   logic [1:0]    pick_idx;
   logic [1:0]    cand;
   logic          mux_out;

   assign any_req     = |req;
   assign release_now = (state == ST_GRANT) && (!req[sel] || (hold_cnt == HOLD_LAST));
   // On release the search already starts after the outgoing owner.
   assign search_base = release_now ? (sel + 2'd1) : ptr;

   always_comb begin
      pick_idx = search_base;
      cand     = search_base;
      for (int k = 3; k >= 0; k--) begin
         cand = search_base + 2'(k);
         if (req[cand]) pick_idx = cand;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         gnt       <= 4'b0000;
         sel       <= 2'd0;
         out_valid <= 1'b0;
         ptr       <= 2'd0;
         hold_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  state     <= ST_GRANT;
                  gnt       <= 4'b0001 << pick_idx;
                  sel       <= pick_idx;
                  out_valid <= 1'b1;
                  hold_cnt  <= '0;
               end
            end
            ST_GRANT: begin
               if (release_now) begin
                  ptr <= sel + 2'd1;
                  if (any_req) begin
                     gnt       <= 4'b0001 << pick_idx;
                     sel       <= pick_idx;
                     out_valid <= 1'b1;
                     hold_cnt  <= '0;
                  end else begin
                     state     <= ST_IDLE;
                     gnt       <= 4'b0000;
                     out_valid <= 1'b0;
                     hold_cnt  <= '0;
                  end
               end else begin
                  hold_cnt <= hold_cnt + HW'(1);
               end
            end
            default: begin
               state     <= ST_IDLE;
               gnt       <= 4'b0000;
               out_valid <= 1'b0;
               hold_cnt  <= '0;
            end
         endcase
      end
   end

   mux_st u_mux (
      .in  (in),
      .sel (sel),
      .out (mux_out)
   );

   assign out = mux_out & out_valid;

endmodule
